// File: rtl/cve2_md_arbiter.sv
// Shares one multiplier/divider between the core MUL/DIV path and the MAC sequencer.
// Round-robin on ties, flush abort, and a watchdog that retires a hung operation.
package cve2_md_arbiter_pkg;
  typedef enum logic [1:0] {
    MD_OP_MULL = 2'd0,
    MD_OP_MULH = 2'd1,
    MD_OP_DIV  = 2'd2,
    MD_OP_REM  = 2'd3
  } md_op_e;
endpackage

module cve2_md_arbiter
  import cve2_md_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 40
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  md_op_e      core_op_i,
  input  logic [1:0]  core_signed_i,
  input  logic [31:0] core_a_i,
  input  logic [31:0] core_b_i,
  output logic        core_valid_o,
  output logic [31:0] core_result_o,
  input  logic        mac_req_i,
  input  md_op_e      mac_op_i,
  input  logic [1:0]  mac_signed_i,
  input  logic [31:0] mac_a_i,
  input  logic [31:0] mac_b_i,
  output logic        mac_valid_o,
  output logic [31:0] mac_result_o,
  output logic        md_mult_en_o,
  output logic        md_div_en_o,
  output md_op_e      md_operator_o,
  output logic [1:0]  md_signed_mode_o,
  output logic [31:0] md_operand_a_o,
  output logic [31:0] md_operand_b_o,
  input  logic        md_valid_i,
  input  logic [31:0] md_result_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        owner_o,
  output logic        timeout_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBusyCore, StBusyMac} state_e;

  state_e          state_q;
  logic            last_q;
  logic [CntW-1:0] cnt_q;
  md_op_e          op_q;
  logic [1:0]      sgn_q;
  logic [31:0]     a_q;
  logic [31:0]     b_q;

  logic busy, is_mac, done, expired, finish, grant_core, grant_mac;

  assign busy   = (state_q != StIdle);
  assign is_mac = (state_q == StBusyMac);

  // Reset in the same cycle aborts the op, so no valid may escape.
  assign done    = busy & md_valid_i & ~flush_i & ~rst_i;
  assign expired = busy & ~md_valid_i & ~flush_i & ~rst_i & (cnt_q == CntLimit);
  assign finish  = done | expired;

  // On a tie the requester that was not granted last wins.
  assign grant_core = core_req_i & (~mac_req_i | last_q);
  assign grant_mac  = mac_req_i & ~grant_core;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      op_q    <= MD_OP_MULL;
      sgn_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (!flush_i && grant_core) begin
            state_q <= StBusyCore;
            last_q  <= 1'b0;
            op_q    <= core_op_i;
            sgn_q   <= core_signed_i;
            a_q     <= core_a_i;
            b_q     <= core_b_i;
          end else if (!flush_i && grant_mac) begin
            state_q <= StBusyMac;
            last_q  <= 1'b1;
            op_q    <= mac_op_i;
            sgn_q   <= mac_signed_i;
            a_q     <= mac_a_i;
            b_q     <= mac_b_i;
          end
        end
        StBusyCore, StBusyMac: begin
          if (flush_i || finish) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign md_mult_en_o     = busy & ((op_q == MD_OP_MULL) | (op_q == MD_OP_MULH));
  assign md_div_en_o      = busy & ((op_q == MD_OP_DIV) | (op_q == MD_OP_REM));
  assign md_operator_o    = op_q;
  assign md_signed_mode_o = sgn_q;
  assign md_operand_a_o   = a_q;
  assign md_operand_b_o   = b_q;

  assign busy_o    = busy;
  assign owner_o   = is_mac;
  assign timeout_o = expired;

  // A timed-out op still hands its owner a valid, with a zero result.
  assign core_valid_o  = finish & ~is_mac;
  assign mac_valid_o   = finish & is_mac;
  assign core_result_o = (done & ~is_mac) ? md_result_i : 32'h0;
  assign mac_result_o  = (done & is_mac) ? md_result_i : 32'h0;

endmodule

// File: tb/tb_cve2_md_arbiter.sv
// Directed bench for cve2_md_arbiter: a vector table of single transactions plus
// hand-written flush, flush-in-idle and mid-op reset sequences.
module tb_cve2_md_arbiter;
  import cve2_md_arbiter_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, mac_req, md_valid, flush;
  md_op_e      core_op, mac_op;
  logic [1:0]  core_sgn, mac_sgn;
  logic [31:0] core_a, core_b, mac_a, mac_b, md_result;
  logic        core_valid_o, mac_valid_o, md_mult_en_o, md_div_en_o;
  logic        busy_o, owner_o, timeout_o;
  logic [31:0] core_result_o, mac_result_o, md_operand_a_o, md_operand_b_o;
  logic [1:0]  md_signed_mode_o;
  md_op_e      md_operator_o;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cve2_md_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .core_req_i      (core_req),
    .core_op_i       (core_op),
    .core_signed_i   (core_sgn),
    .core_a_i        (core_a),
    .core_b_i        (core_b),
    .core_valid_o    (core_valid_o),
    .core_result_o   (core_result_o),
    .mac_req_i       (mac_req),
    .mac_op_i        (mac_op),
    .mac_signed_i    (mac_sgn),
    .mac_a_i         (mac_a),
    .mac_b_i         (mac_b),
    .mac_valid_o     (mac_valid_o),
    .mac_result_o    (mac_result_o),
    .md_mult_en_o    (md_mult_en_o),
    .md_div_en_o     (md_div_en_o),
    .md_operator_o   (md_operator_o),
    .md_signed_mode_o(md_signed_mode_o),
    .md_operand_a_o  (md_operand_a_o),
    .md_operand_b_o  (md_operand_b_o),
    .md_valid_i      (md_valid),
    .md_result_i     (md_result),
    .flush_i         (flush),
    .busy_o          (busy_o),
    .owner_o         (owner_o),
    .timeout_o       (timeout_o)
  );

  typedef struct {
    logic        core_req;
    logic        mac_req;
    md_op_e      op;
    logic [1:0]  sgn;
    logic [31:0] core_a;
    logic [31:0] mac_a;
    logic [31:0] b;
    int          lat;       // busy cycle in which the unit answers; > TO means never
    logic        exp_owner;
    logic [31:0] exp_res;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  function automatic logic [31:0] unit_model(input md_op_e op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      MD_OP_MULL: return p[31:0];
      MD_OP_MULH: return p[63:32];
      MD_OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default:    return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic done_seen;
    int   exp_k;
    logic [1:0] exp_sgn;
    logic exp_mul;
    exp_k   = (v.lat <= TO) ? v.lat : TO;
    exp_sgn = v.exp_owner ? ~v.sgn : v.sgn;
    exp_mul = (v.op == MD_OP_MULL) || (v.op == MD_OP_MULH);
    core_req = v.core_req; mac_req = v.mac_req;
    core_op  = v.op;       mac_op  = v.op;
    core_sgn = v.sgn;      mac_sgn = ~v.sgn;
    core_a   = v.core_a;   mac_a   = v.mac_a;
    core_b   = v.b;        mac_b   = v.b;
    @(negedge clk);
    chk($sformatf("v%0d_idle_busy", idx), 32'(busy_o), 0);
    cyc();
    done_seen = 1'b0;
    for (int k = 1; k <= TO + 2 && !done_seen; k++) begin
      if (k == 2) begin
        // Requester inputs must be ignored once the op is in flight.
        core_a = 5; mac_a = 5; core_b = 1; mac_b = 1;
        core_op = MD_OP_MULH; mac_op = MD_OP_MULH;
      end
      md_valid  = (k == v.lat);
      md_result = md_valid ? unit_model(md_operator_o, md_operand_a_o, md_operand_b_o)
                           : 32'hDEAD_BEEF;
      @(negedge clk);
      if (k == 1) begin
        chk($sformatf("v%0d_busy", idx), 32'(busy_o), 1);
        chk($sformatf("v%0d_owner", idx), 32'(owner_o), 32'(v.exp_owner));
        chk($sformatf("v%0d_mult_en", idx), 32'(md_mult_en_o), 32'(exp_mul));
        chk($sformatf("v%0d_div_en", idx), 32'(md_div_en_o), 32'(!exp_mul));
        chk($sformatf("v%0d_signed", idx), 32'(md_signed_mode_o), 32'(exp_sgn));
      end
      if (core_valid_o || mac_valid_o || timeout_o) begin
        done_seen = 1'b1;
        chk($sformatf("v%0d_done_cycle", idx), k, exp_k);
        chk($sformatf("v%0d_timeout", idx), 32'(timeout_o), 32'(v.lat > TO));
        chk($sformatf("v%0d_core_valid", idx), 32'(core_valid_o), 32'(!v.exp_owner));
        chk($sformatf("v%0d_mac_valid", idx), 32'(mac_valid_o), 32'(v.exp_owner));
        chk($sformatf("v%0d_core_res", idx), core_result_o, v.exp_owner ? 0 : v.exp_res);
        chk($sformatf("v%0d_mac_res", idx), mac_result_o, v.exp_owner ? v.exp_res : 0);
      end
      cyc();
    end
    md_valid = 1'b0;
    if (!done_seen) chk($sformatf("v%0d_completion_seen", idx), 0, 1);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1, 1, MD_OP_MULL, 2'b00, 7, 8, 6, 3, 0, 42};
    vecs[1] = '{1, 1, MD_OP_MULL, 2'b01, 7, 8, 6, 3, 1, 48};
    vecs[2] = '{1, 1, MD_OP_MULL, 2'b10, 7, 8, 6, 2, 0, 42};
    vecs[3] = '{1, 0, MD_OP_MULH, 2'b11, 32'h8000_0000, 0, 4, 2, 0, 2};
    vecs[4] = '{0, 1, MD_OP_DIV,  2'b00, 0, 100, 7, 3, 1, 14};
    vecs[5] = '{0, 1, MD_OP_REM,  2'b01, 0, 100, 7, 1, 1, 2};
    vecs[6] = '{1, 0, MD_OP_REM,  2'b00, 17, 0, 5, 4, 0, 2};
    vecs[7] = '{1, 0, MD_OP_MULL, 2'b00, 3, 0, 5, 99, 0, 0};
    vecs[8] = '{0, 1, MD_OP_MULL, 2'b00, 0, 9, 9, 99, 1, 0};

    rst = 1'b1; core_req = 0; mac_req = 0; md_valid = 0; flush = 0;
    core_op = MD_OP_MULL; mac_op = MD_OP_MULL; core_sgn = 0; mac_sgn = 0;
    core_a = 0; core_b = 0; mac_a = 0; mac_b = 0; md_result = 0;
    cyc(); cyc();
    @(negedge clk);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_enables", 32'({md_mult_en_o, md_div_en_o}), 0);
    chk("rst_valids", 32'({core_valid_o, mac_valid_o, timeout_o, owner_o}), 0);
    cyc();
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);
    core_req = 0; mac_req = 0;

    // Flush in the 2nd busy cycle of a core DIV, with a mac request pending.
    core_req = 1; core_op = MD_OP_DIV; core_a = 50; core_b = 5; core_sgn = 0;
    mac_op = MD_OP_MULL; mac_a = 3; mac_b = 3; mac_sgn = 0;
    cyc();
    mac_req = 1;
    cyc();
    flush = 1;
    @(negedge clk);
    chk("fl_core_valid", 32'(core_valid_o), 0);
    cyc();
    flush = 0; core_req = 0;
    @(negedge clk);
    chk("fl_after_busy", 32'(busy_o), 0);
    chk("fl_after_div_en", 32'(md_div_en_o), 0);
    cyc();
    md_valid = 1; md_result = unit_model(md_operator_o, md_operand_a_o, md_operand_b_o);
    @(negedge clk);
    chk("fl_mac_owner", 32'(owner_o), 1);
    chk("fl_mac_mult_en", 32'(md_mult_en_o), 1);
    chk("fl_mac_result", mac_result_o, 9);
    cyc();
    md_valid = 0; mac_req = 0;

    // Flush coincident with the unit's valid.
    core_req = 1; core_op = MD_OP_MULL; core_a = 2; core_b = 3;
    cyc();
    cyc();
    md_valid = 1; md_result = 6; flush = 1;
    @(negedge clk);
    chk("flv_core_valid", 32'(core_valid_o), 0);
    chk("flv_core_result", core_result_o, 0);
    chk("flv_timeout", 32'(timeout_o), 0);
    cyc();
    md_valid = 0; flush = 0; core_req = 0;
    @(negedge clk);
    chk("flv_after_busy", 32'(busy_o), 0);
    chk("flv_after_mult_en", 32'(md_mult_en_o), 0);
    cyc();

    // Flush while idle blocks the grant for that edge only.
    core_req = 1; flush = 1;
    cyc();
    flush = 0;
    @(negedge clk);
    chk("fli_no_grant", 32'(busy_o), 0);
    cyc();
    md_valid = 1; md_result = unit_model(md_operator_o, md_operand_a_o, md_operand_b_o);
    @(negedge clk);
    chk("fli_core_result", core_result_o, 6);
    cyc();
    md_valid = 0; core_req = 0;

    // Reset during BUSY_MAC with a core request held.
    mac_req = 1; mac_op = MD_OP_MULL; mac_a = 4; mac_b = 4;
    cyc();
    cyc();
    rst = 1; core_req = 1; md_valid = 1; md_result = 16;
    @(negedge clk);
    chk("rmo_mac_valid_in_rst", 32'(mac_valid_o), 0);
    cyc();
    rst = 0; md_valid = 0; mac_req = 0;
    @(negedge clk);
    chk("rmo_busy_owner", 32'({busy_o, owner_o}), 0);
    chk("rmo_enables", 32'({md_mult_en_o, md_div_en_o}), 0);
    chk("rmo_valids", 32'({core_valid_o, mac_valid_o, timeout_o}), 0);
    chk("rmo_results", core_result_o | mac_result_o, 0);
    chk("rmo_operands", md_operand_a_o | md_operand_b_o, 0);
    cyc();
    md_valid = 1; md_result = unit_model(md_operator_o, md_operand_a_o, md_operand_b_o);
    @(negedge clk);
    chk("rmo_regrant_owner", 32'({busy_o, owner_o}), 32'b10);
    chk("rmo_core_result", core_result_o, 6);
    cyc();
    md_valid = 0; core_req = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got running, expected finished");
    $fatal(1);
  end

endmodule

// File: doc/cve2_md_arbiter.md
# cve2_md_arbiter

Arbitrates the core's single shared multiplier/divider unit between two requesters: the regular MUL/DIV path from the ID/EX stage (core) and the MAC sequencer (mac). One operation is in flight at a time. Operands are latched at grant, and the result is routed back to the owner with a one-cycle valid pulse. The block adds round-robin fairness on simultaneous requests, a pipeline flush abort, and a watchdog timeout on a hung unit.

## Interface
- TIMEOUT_CYCLES, 40, maximum BUSY cycles before abort (must be ≥2; a division takes ≤37 cycles)
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- core_req_i  in  1  core requests an op; held high until core_valid_o
- core_op_i  in  md_op_e  MD_OP_MULL/MULH/DIV/REM
- core_signed_i  in  2  signed mode {b_signed, a_signed}
- core_a_i, core_b_i  in  32 each  operands
- core_valid_o  out  1  core result valid (1-cycle pulse)
- core_result_o  out  32  result to core
- mac_req_i, mac_op_i, mac_signed_i, mac_a_i, mac_b_i, mac_valid_o, mac_result_o: same as the core_* ports, for the MAC sequencer
- md_mult_en_o  out  1  multiplier enable
- md_div_en_o  out  1  divider enable
- md_operator_o  out  md_op_e  operator to the unit
- md_signed_mode_o  out  2  signed mode to the unit
- md_operand_a_o, md_operand_b_o  out  32 each  latched operands
- md_valid_i  in  1  unit result valid
- md_result_i  in  32  unit result
- flush_i  in  1  pipeline flush; aborts the in-flight op
- busy_o  out  1  op in flight
- owner_o  out  1  0 = core, 1 = mac (valid only while busy_o)
- timeout_o  out  1  watchdog fired (1-cycle pulse)

## Operation
- States: IDLE, BUSY_CORE, BUSY_MAC.
- Grants are issued from IDLE only.
- IDLE, flush_i=0, one request high → latch that requester's op, signed mode and operands. Go to BUSY_<req>. Set last_q to the grantee.
- IDLE, both requests high → grant the requester ≠ last_q.
- last_q resets to 1, so core wins the first tie.
- IDLE, flush_i=1 → no grant.
- In BUSY:
  - md_mult_en_o = 1 if the latched op is MULL/MULH; md_div_en_o = 1 if DIV/REM.
  - md_operator_o, md_signed_mode_o and md_operand_*_o come from the latch and are stable for the whole op.
  - busy_o = 1; owner_o = state.
- BUSY, md_valid_i=1, flush_i=0 → owner's valid_o=1 and result_o=md_result_i combinationally in the same cycle; next state IDLE. The non-owner valid_o stays 0.
- BUSY, flush_i=1 → next state IDLE. No valid is generated, even if md_valid_i is high in the same cycle. The enables drop the next cycle.
- Watchdog:
  - cnt_q clears on BUSY entry and increments each BUSY cycle.
  - If cnt_q == TIMEOUT_CYCLES-1, md_valid_i=0 and flush_i=0 → timeout_o=1, owner valid_o=1 with result_o=32'h0; next state IDLE.
  - md_valid_i in the limit cycle wins over the timeout (normal completion).
  - flush_i in the limit cycle wins over both.
- Requester input changes during BUSY are ignored. A request dropped mid-op still receives its valid pulse.
- result_o for any requester is 32'h0 whenever its valid_o=0.
- Reset (any cycle, including mid-op):
  - state IDLE, last_q=1, cnt_q=0, operand/op/signed latches 0.
  - All outputs 0: enables, valids, results, busy_o, owner_o, timeout_o.
  - The aborted op produces no valid.

## Timing
- Grant latency: a request seen high in IDLE at edge N → BUSY and enables high from cycle N+1.
- Completion: valid_o is asserted in the same cycle as md_valid_i (zero added latency).
- After completion, the FSM spends exactly one cycle in IDLE before it can re-grant.
- Minimum request-to-request spacing per unit: op latency + 1 cycle.
- Watchdog: timeout_o fires in the TIMEOUT_CYCLES-th BUSY cycle (cnt_q counts 0..TIMEOUT_CYCLES-1).
- The enables are driven from registered state only, so there is no combinational path from req_i to md_*_en_o. Valid/result have a combinational path from md_valid_i/md_result_i.

## Test plan
- Core only: MULL, a=7, b=6; unit returns valid 3 cycles after the enable → md_mult_en_o high 3 cycles, core_valid_o pulses with 42, mac_valid_o stays 0, busy_o drops the next cycle.
- Tie: core and mac request together out of reset, then both hold → core granted first; after its valid and one IDLE cycle, mac granted; the next tie goes to core again (alternation).
- Operand stability: grant mac DIV a=100, b=7, then change mac_a_i to 5 during BUSY → md_operand_a_o stays 100, md_div_en_o high, mac_result_o=14.
- Flush: flush_i in the 2nd BUSY cycle of a core DIV, and separately flush_i coincident with md_valid_i → no core_valid_o in either case, enables low the next cycle, IDLE, a pending mac request granted one cycle later.
- Watchdog: TIMEOUT_CYCLES=4, md_valid_i never asserted → timeout_o and core_valid_o pulse in BUSY cycle 4 with result 0. A rerun with md_valid_i in cycle 4 gives a normal result and timeout_o=0.
- Reset mid-op: rst_i for one cycle during BUSY_MAC → next cycle all outputs 0 and no mac_valid_o. A held core request is granted on the first edge after rst_i deasserts.
